// File: rtl/regfile_mp.sv
// regfile_mp: NRD combinational read ports, two prioritised write ports, and a clear-sweep FSM.
// Optional per-entry pending scoreboard is enabled by defining REGFILE_SCOREBOARD_EN.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clr_req,
  output logic                  clr_busy,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [DATA_W-1:0]     wdata1
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic [NRD-1:0]        rpend
`endif
);

  localparam int DEPTH = 32'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] LAST_A  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   cnt_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic                idle_s;
  logic                wr0_s;
  logic                wr1_s;

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic: sweep ends on the last entry, clr_req only honoured in IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (cnt_r == LAST_A) state_nxt_s = ST_IDLE;
        else                 state_nxt_s = ST_CLEAR;
      end
      ST_IDLE: begin
        if (clr_req) state_nxt_s = ST_CLEAR;
        else         state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_CLEAR;
    endcase
  end

  // FSM output decode
  always_comb begin
    clr_busy = 1'b1;
    idle_s   = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        clr_busy = 1'b1;
        idle_s   = 1'b0;
      end
      ST_IDLE: begin
        clr_busy = 1'b0;
        idle_s   = 1'b1;
      end
      default: begin
        clr_busy = 1'b1;
        idle_s   = 1'b0;
      end
    endcase
  end

  // Sweep counter: runs only in CLEAR and wraps to zero as the sweep ends
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= ZERO_A;
    end else if (state_r == ST_CLEAR) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= ZERO_A;
    end
  end

  // Port 1 wins a same-address collision, so port 0 is suppressed there
  assign wr1_s = idle_s & we1 & (waddr1 != ZERO_A);
  assign wr0_s = idle_s & we0 & (waddr0 != ZERO_A) & ~(wr1_s & (waddr1 == waddr0));

  // Storage array: sweep clears one entry per cycle, otherwise commit writes
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[cnt_r] <= {DATA_W{1'b0}};
    end else begin
      if (wr0_s) mem_r[waddr0] <= wdata0;
      if (wr1_s) mem_r[waddr1] <= wdata1;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pend_r;
  logic [DEPTH-1:0] pend_nxt_s;
  logic             set_s;

  assign set_s = idle_s & iss_en & (iss_addr != ZERO_A);

  // Pending update: any write attempt clears, issue sets afterwards so set wins
  always_comb begin
    pend_nxt_s = pend_r;
    pend_nxt_s[waddr0]   = (idle_s & we0) ? 1'b0 : pend_nxt_s[waddr0];
    pend_nxt_s[waddr1]   = (idle_s & we1) ? 1'b0 : pend_nxt_s[waddr1];
    pend_nxt_s[iss_addr] = set_s ? 1'b1 : pend_nxt_s[iss_addr];
  end

  // Pending register: zeroed on reset, while sweeping and on the edge that enters CLEAR
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_r <= {DEPTH{1'b0}};
    end else if (!idle_s || clr_req) begin
      pend_r <= {DEPTH{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
    end
  end
`endif

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic [DATA_W-1:0] rd_s;

    assign ra_s = raddr[gi*ADDR_W +: ADDR_W];

    // Read mux with write-through bypass; forced to zero in CLEAR and for entry 0
    always_comb begin
      rd_s = {DATA_W{1'b0}};
      if (!idle_s || (ra_s == ZERO_A)) begin
        rd_s = {DATA_W{1'b0}};
      end else if (wr1_s && (waddr1 == ra_s)) begin
        rd_s = wdata1;
      end else if (we0 && (waddr0 == ra_s)) begin
        rd_s = wdata0;
      end else begin
        rd_s = mem_r[ra_s];
      end
    end

    assign rdata[gi*DATA_W +: DATA_W] = rd_s;

`ifdef REGFILE_SCOREBOARD_EN
    assign rpend[gi] = idle_s & (ra_s != ZERO_A) & pend_r[ra_s]
                     & ~(we0 & (waddr0 == ra_s)) & ~(we1 & (waddr1 == ra_s));
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a behavioural model predicts outputs each cycle,
// expectations are queued when stimulus is driven and compared at the following negedge.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        clr_req = 1'b0;
  logic        clr_busy;
  logic [4:0]  ra0 = 5'd0;
  logic [4:0]  ra1 = 5'd0;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic        we0 = 1'b0;
  logic [4:0]  waddr0 = 5'd0;
  logic [31:0] wdata0 = 32'd0;
  logic        we1 = 1'b0;
  logic [4:0]  waddr1 = 5'd0;
  logic [31:0] wdata1 = 32'd0;
`ifdef REGFILE_SCOREBOARD_EN
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = 5'd0;
  logic [1:0]  rpend;
`endif

  assign raddr = {ra1, ra0};

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .raddr    (raddr),
    .rdata    (rdata),
    .we0      (we0),
    .waddr0   (waddr0),
    .wdata0   (wdata0),
    .we1      (we1),
    .waddr1   (waddr1),
    .wdata1   (wdata1)
`ifdef REGFILE_SCOREBOARD_EN
    ,
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .rpend    (rpend)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_pend = 32'd0;
  logic        m_busy = 1'b1;
  logic [4:0]  m_cnt = 5'd0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] ra);
    if (m_busy || ra == 5'd0) return 32'd0;
    if (we1 && waddr1 == ra)  return wdata1;
    if (we0 && waddr0 == ra)  return wdata0;
    return m_mem[ra];
  endfunction

  function automatic logic [31:0] model_pend(input logic [4:0] ra);
    if (m_busy || ra == 5'd0) return 32'd0;
    if ((we0 && waddr0 == ra) || (we1 && waddr1 == ra)) return 32'd0;
    return {31'd0, m_pend[ra]};
  endfunction

  // One clock: queue model predictions (plus an optional fixed expectation), compare, advance model
  task automatic tick(input string tag, input int csel, input logic [31:0] cval);
    sb_entry_t e;
    if (!resetn) begin
      m_busy = 1'b1;
      m_cnt  = 5'd0;
      m_pend = 32'd0;
    end
    sb_q.push_back('{{tag, ".rd0"}, 0, model_rd(ra0)});
    sb_q.push_back('{{tag, ".rd1"}, 1, model_rd(ra1)});
    sb_q.push_back('{{tag, ".busy"}, 2, {31'd0, m_busy}});
`ifdef REGFILE_SCOREBOARD_EN
    sb_q.push_back('{{tag, ".pend0"}, 3, model_pend(ra0)});
    sb_q.push_back('{{tag, ".pend1"}, 4, model_pend(ra1)});
`endif
    if (csel >= 0) sb_q.push_back('{{tag, ".fixed"}, csel, cval});
    @(negedge clk);
    while (sb_q.size() != 0) begin
      logic [31:0] obs;
      e = sb_q.pop_front();
      case (e.sel)
        0: obs = rdata[31:0];
        1: obs = rdata[63:32];
        2: obs = {31'd0, clr_busy};
`ifdef REGFILE_SCOREBOARD_EN
        3: obs = {31'd0, rpend[0]};
        4: obs = {31'd0, rpend[1]};
`endif
        default: obs = 32'hxxxxxxxx;
      endcase
      check_val(e.tag, obs, e.val);
    end
    @(posedge clk);
    if (resetn) begin
      if (m_busy) begin
        m_mem[m_cnt] = 32'd0;
        if (m_cnt == 5'd31) m_busy = 1'b0;
        m_cnt = m_cnt + 5'd1;
      end else begin
`ifdef REGFILE_SCOREBOARD_EN
        if (we0) m_pend[waddr0] = 1'b0;
        if (we1) m_pend[waddr1] = 1'b0;
        if (iss_en && iss_addr != 5'd0) m_pend[iss_addr] = 1'b1;
        m_pend[0] = 1'b0;
        if (clr_req) m_pend = 32'd0;
`endif
        if (we0 && waddr0 != 5'd0) m_mem[waddr0] = wdata0;
        if (we1 && waddr1 != 5'd0) m_mem[waddr1] = wdata1;
        if (clr_req) begin
          m_busy = 1'b1;
          m_cnt  = 5'd0;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
`ifdef REGFILE_SCOREBOARD_EN
    iss_en = 1'b0;
`endif
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;

    // Held reset: busy, zero reads; then a mid-sweep reset that must restart the sweep
    for (int i = 0; i < 3; i++) tick("rst_hold", 2, 32'd1);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) tick("sweep_a", -1, 32'd0);
    resetn = 1'b0;
    tick("rst_mid", 2, 32'd1);
    resetn = 1'b1;
    n = 0;
    while (clr_busy && n < 100) begin
      ra0 = 5'(n); ra1 = 5'(31 - n);
      tick("sweep_b", 0, 32'd0);
      n++;
    end
    check_val("busy_len_reset", 32'(n), 32'd32);

    // Same-address dual write: port 1 wins, bypass and stored value
    ra0 = 5'd3; ra1 = 5'd4;
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h11111111;
    we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h22222222;
    tick("dual_bypass", 0, 32'h22222222);
    idle_inputs();
    tick("dual_stored", 0, 32'h22222222);

    // Writes to entry 0 are discarded and it reads as zero
    ra0 = 5'd0;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    tick("zero_bypass", 0, 32'd0);
    idle_inputs();
    tick("zero_after", 0, 32'd0);

    // Write 7, then clear request alongside a write to 8; extra clr_req mid-sweep is ignored
    ra0 = 5'd7; ra1 = 5'd8;
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hDEADBEEF;
    tick("wr7", -1, 32'd0);
    we0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'h00000005; clr_req = 1'b1;
    tick("clr_with_wr", 1, 32'h00000005);
    idle_inputs();
    n = 0;
    while (clr_busy && n < 100) begin
      clr_req = (n >= 5 && n <= 8) ? 1'b1 : 1'b0;
      we1 = (n == 10) ? 1'b1 : 1'b0; waddr1 = 5'd7; wdata1 = 32'h12345678;
      tick("sweep_c", 0, 32'd0);
      n++;
    end
    idle_inputs();
    check_val("busy_len_clr", 32'(n), 32'd32);
    tick("after_clr", 0, 32'd0);
    check_val("after_clr_rd8", rdata[63:32], 32'd0);

`ifdef REGFILE_SCOREBOARD_EN
    // Pending bits: issue sets, write clears (same cycle), set wins over a same-cycle write
    ra0 = 5'd9; ra1 = 5'd0;
    iss_en = 1'b1; iss_addr = 5'd9;
    tick("iss9", -1, 32'd0);
    idle_inputs();
    tick("pend9_set", 3, 32'd1);
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hA5A5A5A5;
    tick("pend9_wr", 3, 32'd0);
    idle_inputs();
    tick("pend9_clr", 3, 32'd0);
    iss_en = 1'b1; iss_addr = 5'd9; we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h5A5A5A5A;
    tick("pend9_both", -1, 32'd0);
    idle_inputs();
    tick("pend9_setwins", 3, 32'd1);
`endif

    // Randomised traffic over a narrow address range to force collisions and bypasses
    for (int i = 0; i < 300; i++) begin
      we0 = 1'($urandom_range(0, 1)); waddr0 = 5'($urandom_range(0, 7)); wdata0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); waddr1 = 5'($urandom_range(0, 7)); wdata1 = $urandom;
      ra0 = 5'($urandom_range(0, 7)); ra1 = 5'($urandom_range(0, 7));
`ifdef REGFILE_SCOREBOARD_EN
      iss_en = 1'($urandom_range(0, 1)); iss_addr = 5'($urandom_range(0, 7));
`endif
      clr_req = ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0;
      tick("rand", -1, 32'd0);
    end
    idle_inputs();
    tick("final", -1, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameters, one per line:
  DATA_W  32  register width in bits
  ADDR_W  5   address width; depth = 2**ADDR_W entries
  NRD     2   number of independent read ports (1..4)
REQ-002 SHALL provide ports, one per line (all addresses ADDR_W, all data DATA_W):
  clk       in   1             single clock; all state updates on rising edge
  resetn    in   1             asynchronous, active-low reset
  clr_req   in   1             request a full-array clear sweep
  clr_busy  out  1             clear sweep in progress
  raddr     in   NRD*ADDR_W    packed read addresses, port i at [i*ADDR_W +: ADDR_W]
  rdata     out  NRD*DATA_W    packed read data, port i at [i*DATA_W +: DATA_W]
  we0       in   1             write enable, port 0
  waddr0    in   ADDR_W        write address, port 0
  wdata0    in   DATA_W        write data, port 0
  we1       in   1             write enable, port 1 (higher priority)
  waddr1    in   ADDR_W        write address, port 1
  wdata1    in   DATA_W        write data, port 1
  iss_en    in   1             scoreboard: mark destination pending (REGFILE_SCOREBOARD_EN only)
  iss_addr  in   ADDR_W        scoreboard: destination address (REGFILE_SCOREBOARD_EN only)
  rpend     out  NRD           scoreboard: read operand i pending (REGFILE_SCOREBOARD_EN only)
REQ-003 SHALL use one clock (clk) and an asynchronous, active-low reset (resetn); no other clock or reset inputs.

Function
REQ-004 Entry 0 SHALL always read as zero; writes to address 0 SHALL be discarded.
REQ-005 Writes SHALL commit on rising clk when we0/we1 is high, the address is nonzero and the FSM is IDLE.
REQ-006 we0 and we1 to the same nonzero address in one cycle: port 1 data SHALL be stored, port 0 discarded.
REQ-007 Reads SHALL be combinational, zero latency, with write-through bypass: rdata_i = wdata1 if (we1 and waddr1==raddr_i), else wdata0 if (we0 and waddr0==raddr_i), else array[raddr_i]. Bypass SHALL apply only in IDLE and only for nonzero raddr_i.
REQ-008 FSM SHALL have two states, CLEAR and IDLE; clr_busy = 1 exactly in CLEAR.
REQ-009 In CLEAR, an ADDR_W-bit sweep counter SHALL zero entry[cnt] each cycle and increment; at cnt == 2**ADDR_W-1 it SHALL zero that entry and go to IDLE next edge (sweep length exactly 2**ADDR_W cycles).
REQ-010 IDLE with clr_req=1 SHALL go to CLEAR with cnt=0 next edge; a write in that same cycle SHALL still commit (and is then swept to zero).
REQ-011 clr_req in CLEAR SHALL be ignored (no restart); writes in CLEAR SHALL be discarded; all rdata SHALL be zero in CLEAR.

Reset
REQ-012 resetn low SHALL immediately force: state CLEAR, cnt 0, clr_busy 1, all rdata 0, all pend bits 0 (rpend 0).
REQ-013 After resetn deasserts, the full REQ-009 sweep SHALL run; the block is usable only when clr_busy falls. Array contents are not reset asynchronously.
REQ-014 resetn assertion mid-sweep SHALL restart the sweep from cnt 0 after deassertion.

Configuration
REQ-015 Macro REGFILE_SCOREBOARD_EN defined: iss_en/iss_addr/rpend exist; per-entry pend bits SET by iss_en (nonzero iss_addr, IDLE only), CLEARED by any committing or discarded-by-priority write to that address; set and clear on the same address in one cycle -> set wins; entering CLEAR zeroes all pend bits; rpend_i = pend[raddr_i] AND NOT (write to raddr_i this cycle); rpend_i = 0 for raddr_i == 0.
REQ-016 Macro undefined: those three ports and all pend state SHALL be absent; all other behaviour unchanged.

Verification
REQ-017 Pulse resetn low, release -> clr_busy high exactly 32 cycles (default ADDR_W), rdata all 0 throughout, then 0.
REQ-018 IDLE: we0 addr 3 data 0x11111111 and we1 addr 3 data 0x22222222 same cycle, raddr0=3 -> rdata0 0x22222222 that cycle (bypass) and after.
REQ-019 we1 addr 0 data 0xFFFFFFFF, raddr0=0 -> rdata0 0x00000000 same cycle and next.
REQ-020 Write addr 7 = 0xDEADBEEF, then clr_req while we0 addr 8 = 0x5 -> both read 0 after sweep; clr_req asserted mid-sweep does not extend 32-cycle busy.
REQ-021 (REGFILE_SCOREBOARD_EN) iss_en addr 9 -> rpend0=1 for raddr0=9 next cycle; we0 addr 9 -> rpend0=0 in write cycle; iss_en addr 9 plus we0 addr 9 same cycle -> rpend0=1 after.
